// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; divider built only with MULDIV_DIV_EN
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic        r_mul_ph;
    logic [63:0] r_prod;
    logic [31:0] r_result;

    logic               w_sa;
    logic               w_sb;
    logic signed [32:0] w_ma;
    logic signed [32:0] w_mb;
    logic signed [63:0] w_ea;
    logic signed [63:0] w_eb;
    logic        [63:0] w_prod;

    // 33-bit signed operands; the 64-bit truncated product is exact for every variant
    assign w_sa   = (r_f3 == 2'b01) || (r_f3 == 2'b10);
    assign w_sb   = (r_f3 == 2'b01);
    assign w_ma   = {w_sa & r_a[31], r_a};
    assign w_mb   = {w_sb & r_b[31], r_b};
    assign w_ea   = w_ma;
    assign w_eb   = w_mb;
    assign w_prod = w_ea * w_eb;

`ifdef MULDIV_DIV_EN
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic        w_sgn_a;
    logic        w_sgn_b;
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    assign w_sgn_a = ~funct3[0] & rs1_val[31];
    assign w_sgn_b = ~funct3[0] & rs2_val[31];
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_q_fin = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_quo : r_quo);
    assign w_r_fin = r_neg_r ? -r_rem : r_rem;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_f3     <= 2'b00;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_rd     <= 5'h0;
            r_mul_ph <= 1'b0;
            r_prod   <= 64'h0;
            r_result <= 32'h0;
`ifdef MULDIV_DIV_EN
            r_rem    <= 32'h0;
            r_quo    <= 32'h0;
            r_dvs    <= 32'h0;
            r_cnt    <= 6'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f3     <= funct3[1:0];
                        r_a      <= rs1_val;
                        r_b      <= rs2_val;
                        r_rd     <= rd_in;
                        r_mul_ph <= 1'b0;
                        if (!funct3[2]) begin
                            r_state <= S_MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            // prologue: magnitudes and result signs fixed at launch
                            r_quo   <= w_sgn_a ? -rs1_val : rs1_val;
                            r_dvs   <= w_sgn_b ? -rs2_val : rs2_val;
                            r_rem   <= 32'h0;
                            r_cnt   <= 6'd0;
                            r_neg_q <= w_sgn_a ^ w_sgn_b;
                            r_neg_r <= w_sgn_a;
                            r_dz    <= (rs2_val == 32'h0);
                            r_state <= S_DIV;
`else
                            r_result <= 32'h0;
                            r_state  <= S_DONE;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (!r_mul_ph) begin
                        r_prod   <= w_prod;
                        r_mul_ph <= 1'b1;
                    end else begin
                        r_result <= (r_f3 == 2'b00) ? r_prod[31:0] : r_prod[63:32];
                        r_mul_ph <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    if (r_cnt != 6'd32) begin
                        if (!w_diff[33]) begin
                            r_rem <= w_diff[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= r_f3[1] ? w_r_fin : w_q_fin;
                        r_state  <= S_DONE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_MUL) || (r_state == S_DIV);
    assign done   = (r_state == S_DONE);
    assign we_out = done;
    assign stall  = start & ~done;
    assign result = r_result;
    assign rd_out = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized scoreboard bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .stall(stall), .busy(busy), .done(done), .result(result),
        .rd_out(rd_out), .we_out(we_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          launch;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'h0, a};
        longint ub = {32'h0, b};
        logic [63:0] p;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f);
`ifdef MULDIV_DIV_EN
        return f[2] ? 33 : 2;
`else
        return f[2] ? -1 : 2;
`endif
    endfunction

    // monitor: pops one expectation for every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'h0, rd_out}, {27'h0, e.rd});
                check("we_out", {31'h0, we_out}, 32'h1);
                check("done_single", {31'h0, prev_done}, 32'h0);
                if (e.lat >= 0) check("latency", cyc - e.launch, e.lat);
            end
        end
        prev_done = done;
    end

    // mode 0: hold start; 1: scramble inputs after launch; 2: drop/re-pulse start while busy
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int mode);
        int   n;
        int   lat;
        logic seen;
        @(negedge clk);
        funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        lat = latency(f);
        sbq.push_back('{model(f, a, b), rd, cyc + 1, lat});
        #1;
        check("stall_pre", {31'h0, stall}, 32'h1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (mode == 1) begin
                rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
            end
            if (mode == 2) start = (n == 2);
            seen = done;
            #1;
            if (lat >= 0) check("busy", {31'h0, busy}, {31'h0, (n <= lat)});
            check("stall", {31'h0, stall}, {31'h0, start & ~seen});
            if (seen) start = 1'b0;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no done in 60 cycles, expected done for funct3=%0d", f);
            sbq.delete();
            start = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] lf;
        int         lw;
        reset = 1'b1; start = 1'b0; funct3 = 3'h0; rs1_val = 32'h0; rs2_val = 32'h0; rd_in = 5'h0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'h0, busy},   32'h0);
        check("rst_done",   {31'h0, done},   32'h0);
        check("rst_we",     {31'h0, we_out}, 32'h0);
        check("rst_stall",  {31'h0, stall},  32'h0);
        check("rst_result", result,          32'h0);
        check("rst_rd",     {27'h0, rd_out}, 32'h0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  1);
        run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd6,  0);
        run_op(3'd7, 32'h0000_0005, 32'h0000_0000, 5'd8,  0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  2);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 5'd11, 0);
        run_op(3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd12, 0);

`ifdef MULDIV_DIV_EN
        lf = 3'd4; lw = 10;
`else
        lf = 3'd0; lw = 1;
`endif
        @(negedge clk);
        funct3 = lf; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd13; start = 1'b1;
        repeat (lw) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(3'd0, 32'd3, 32'd4, 5'd14, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
